seq_add32_slicer: RTL and testbench

- Multi-cycle 32-bit adder front end.
- Latches one operand pair, then drives one 4-bit ripple-carry slice adder per cycle, least-significant slice first.
- Registers each slice sum and chains the slice carry-out into the next slice's carry-in.
- Trades latency for area against the flat 32-bit chain; sits between the operand source and the result consumer, each side using valid/ready.

---
 rtl/seq_add32_slicer_pkg.sv | 16 +
 rtl/RCA_4.sv | 25 ++
 rtl/seq_add32_slicer.sv | 104 ++++++++++
 tb/tb_seq_add32_slicer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_add32_slicer_pkg.sv
// Shared widths and state encoding for the slice-serial 32-bit adder.
`timescale 1ns/1ps
package seq_add32_slicer_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_4.sv
// 4-bit ripple-carry slice adder shared with the flat adder library.
`timescale 1ns/1ps
module RCA_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: rtl/seq_add32_slicer.sv
// Multi-cycle adder: one 4-bit slice per cycle, LSB slice first, carry chained through a register.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
`timescale 1ns/1ps
module seq_add32_slicer
    import seq_add32_slicer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t state;
    state_t state_next;

    logic [NSLICE-1:0][SLICE-1:0] a_reg;
    logic [NSLICE-1:0][SLICE-1:0] b_reg;
    logic [NSLICE-1:0][SLICE-1:0] sum_reg;
    logic                         carry_reg;
    logic                         cout_reg;
    logic [IDXW-1:0]              idx;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             last_slice;

    assign last_slice = (idx == IDXW'(NSLICE - 1));

    RCA_4 u_rca (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // No skid: the consumer's accept only frees the input side one cycle later.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // sum_reg is not cleared on accept, so the previous result stays visible until RUN overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= slice_sum;
                    carry_reg    <= slice_cout;
                    idx          <= idx + 1'b1;
                    if (last_slice) begin
                        cout_reg <= slice_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_seq_add32_slicer.sv
// Directed and random bench for seq_add32_slicer with a queue-based result scoreboard.
`timescale 1ns/1ps
module tb_seq_add32_slicer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    int checks = 0;
    int errors = 0;
    bit rand_done = 0;

    seq_add32_slicer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", {cout, sum});
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {31'd0, cout, sum}, {31'd0, mon_exp});
            end
        end
    end

    // Present an operand pair until accepted; returns the number of idle negedges waited.
    task automatic send(input logic [31:0] sa, input logic [31:0] sb, input logic sc,
                        input logic [32:0] expv, input bit push, output int waits);
        bit acc;
        acc      = 0;
        waits    = 0;
        in_valid = 1'b1;
        a        = sa;
        b        = sb;
        cin      = sc;
        while (!acc && waits <= 200) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            else          waits++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            if (push) exp_q.push_back(expv);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        bit found;
        found = 0;
        k     = 0;
        while (!found && k < 50) begin
            @(negedge clk);
            k++;
            if (out_valid) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1 within 50 cycles");
        end
    endtask

    initial begin
        int k;
        int w;
        int seen;
        int n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Async reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add and latency.
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 33'h0_0000_0003, 1, w);
        wait_valid(k);
        check("basic_latency", 64'(k), 64'd9);
        @(posedge clk);
        #1;

        // Carry ripples through every slice.
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1, w);
        wait_valid(k);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_hold_sum", {32'd0, sum}, 64'd0);
        check("idle_hold_cout", {63'd0, cout}, 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: DONE holds, in_valid ignored.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1, w);
        wait_valid(k);
        check("bp_latency", 64'(k), 64'd9);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_sum", {32'd0, sum}, 64'h2345_6789);
            check("bp_cout", {63'd0, cout}, 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("no_skid_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        send(32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 33'h0_1F1F_1F1F, 1, w);
        check("accept_after_done", 64'(w), 64'd0);
        wait_valid(k);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN discards the operation.
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h0, 0, w);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_sum", {32'd0, sum}, 64'd0);
        check("midrst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 33'h0_0000_000C, 1, w);
        wait_valid(k);
        @(posedge clk);
        #1;

        // Back-to-back random traffic with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    case (i)
                        0:       begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rc = 1'b1; end
                        1:       begin ra = 32'h0000_0000; rb = 32'h0000_0000; rc = 1'b0; end
                        default: begin ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); end
                    endcase
                    send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'd0, rc}, 1, w);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
